// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// The owner id type is one bit wide: inst side is 0, data side is 1.
package sram_port_arbiter_pkg;

    typedef enum logic {
        ARB_INST = 1'b0,
        ARB_DATA = 1'b1
    } arb_id_t;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_req_t;

    localparam int SRAM_ARB_OUTSTANDING_DEFAULT = 2;

    // The requester that is not the given one; used by round-robin selection.
    function automatic arb_id_t other_id(input arb_id_t id);
        return (id == ARB_INST) ? ARB_DATA : ARB_INST;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_arb_id_fifo.sv
// In-order FIFO of owner ids for transactions accepted downstream but not
// yet answered. Head is the owner of the next response to come back.
module arb_id_fifo
    import sram_port_arbiter_pkg::*;
#(
    parameter int  DEPTH = SRAM_ARB_OUTSTANDING_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  arb_id_t          push_id,
    input  logic             pop,
    output arb_id_t          head,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);

    arb_id_t          slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop on an empty FIFO is dropped; a push into a full FIFO only lands
    // when a pop frees the head slot in the same cycle.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Write side: store the new owner at the tail.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= ARB_INST;
            end
            wr_ptr <= '0;
        end else if (do_push) begin
            slots[wr_ptr] <= push_id;
            wr_ptr        <= next_ptr(wr_ptr);
        end
    end

    // Read side: advance past the head once its response has been routed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
        end else if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Occupancy: simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Status flags and head are read straight from the stored state.
    always_comb begin
        head  = slots[rd_ptr];
        full  = (cnt == CNT_W'(DEPTH));
        empty = (cnt == '0);
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one downstream SRAM-like port between the inst and data requesters
// and steers every response back to the requester that issued it.
// Optional feature: define SRAM_ARB_RR_EN to replace fixed data-over-inst
// priority by round-robin when both requesters are active and unlocked.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = SRAM_ARB_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);

    sram_req_t        inst_fields;
    sram_req_t        data_fields;
    sram_req_t        m_fields;
    arb_id_t          grant_id;
    arb_id_t          lock_id;
    arb_id_t          head_id;
    lock_state_t      lock_state;
    logic             lock;
    logic             grant_req;
    logic             accept;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;

`ifdef SRAM_ARB_RR_EN
    arb_id_t          rr_last;
`endif

    // Bundle each requester's command so the port mux is a single select.
    always_comb begin
        inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                        addr: inst_addr, wdata: inst_wdata};
        data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};
    end

    // Pick the requester that owns the port this cycle; a pending lock
    // overrides any priority decision so a stalled command is never swapped.
    always_comb begin
        lock     = (lock_state == LOCK_HELD);
        grant_id = ARB_INST;
        if (lock) begin
            grant_id = lock_id;
        end else begin
`ifdef SRAM_ARB_RR_EN
            if (inst_req && data_req) begin
                grant_id = other_id(rr_last);
            end else if (data_req) begin
                grant_id = ARB_DATA;
            end
`else
            if (data_req) begin
                grant_id = ARB_DATA;
            end
`endif
        end
        grant_req = (grant_id == ARB_DATA) ? data_req : inst_req;
    end

    // Drive the downstream port; nothing is offered while reset is held or
    // while every outstanding slot is in use, even if a response pops now.
    always_comb begin
        m_req    = resetn && grant_req && !fifo_full;
        m_fields = '0;
        if (resetn) begin
            m_fields = (grant_id == ARB_DATA) ? data_fields : inst_fields;
        end
        m_wr    = m_fields.wr;
        m_size  = m_fields.size;
        m_wstrb = m_fields.wstrb;
        m_addr  = m_fields.addr;
        m_wdata = m_fields.wdata;
    end

    // Acceptance and response routing, both without added latency.
    always_comb begin
        accept       = m_req && m_addr_ok;
        inst_addr_ok = accept && (grant_id == ARB_INST);
        data_addr_ok = accept && (grant_id == ARB_DATA);
        pop          = resetn && m_data_ok && !fifo_empty;
        inst_data_ok = pop && (head_id == ARB_INST);
        data_data_ok = pop && (head_id == ARB_DATA);
        inst_rdata   = m_rdata;
        data_rdata   = m_rdata;
    end

    // Lock FSM: a request that is offered but not accepted pins the port to
    // that requester until the downstream side takes it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state <= LOCK_IDLE;
            lock_id    <= ARB_INST;
        end else begin
            case (lock_state)
                LOCK_IDLE: begin
                    if (m_req && !m_addr_ok) begin
                        lock_state <= LOCK_HELD;
                        lock_id    <= grant_id;
                    end
                end
                LOCK_HELD: begin
                    if (m_req && m_addr_ok) begin
                        lock_state <= LOCK_IDLE;
                    end
                end
                default: begin
                    lock_state <= LOCK_IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_last <= ARB_INST;
        end else if (accept) begin
            rr_last <= grant_id;
        end
    end
`endif

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (grant_id),
        .pop     (pop),
        .head    (head_id),
        .cnt     (fifo_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifndef SYNTHESIS
    // Report a response that arrives while nothing is outstanding; it is
    // dropped without touching any state.
    always_ff @(posedge clk) begin
        if (resetn && m_data_ok) begin
            spurious_data_ok: assert (fifo_cnt != '0)
                else $warning("sram_port_arbiter: m_data_ok with no outstanding transaction ignored");
        end
    end

    // The owner FIFO must never be asked to grow past its depth.
    always_ff @(posedge clk) begin
        if (resetn && accept) begin
            no_overflow: assert (!fifo_full)
                else $error("sram_port_arbiter: acceptance with owner FIFO full");
        end
    end
`endif

endmodule
